// File: rtl/b_aluctrl_pkg.sv
// Shared encodings for the ALU control path: ALU operation select codes,
// main-control operation classes and R-type funct field values.
package b_aluctrl_pkg;

    // ALU operation select presented to the ALU
    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_SLL   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_MULTU = 4'b1000,
        ALU_LUI   = 4'b1001,
        ALU_PASS  = 4'b1010,
        ALU_NOR   = 4'b1100,
        ALU_NOP   = 4'b1111
    } alu_ctr_e;

    // Operation class from main control; bit 3 set means "decode funct"
    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SLT   = 4'b0001,
        OP_SUB   = 4'b0010,
        OP_RSV3  = 4'b0011,
        OP_AND   = 4'b0100,
        OP_OR    = 4'b0101,
        OP_RSV6  = 4'b0110,
        OP_LUI   = 4'b0111,
        OP_RTYPE = 4'b1000
    } alu_op_e;

    // R-type funct field, instr[5:0]
    typedef enum logic [5:0] {
        F_SLL   = 6'b000000,
        F_SRL   = 6'b000010,
        F_JR    = 6'b001000,
        F_JALR  = 6'b001001,
        F_MULTU = 6'b011001,
        F_ADD   = 6'b100000,
        F_SUB   = 6'b100010,
        F_AND   = 6'b100100,
        F_OR    = 6'b100101,
        F_XOR   = 6'b100110,
        F_NOR   = 6'b100111,
        F_SLT   = 6'b101010
    } funct_e;

    localparam int ALU_OP_W = 4;
    localparam int FUNCT_W  = 6;
    localparam int ALU_CTR_W = 4;

endpackage

// File: rtl/b_aluctrl_dec.sv
// Combinational ALU control decoder. The R-type path looks only at funct and
// the immediate/class path looks only at alu_op, so unknowns on the unused
// field never reach the result.
module b_aluctrl_dec
    import b_aluctrl_pkg::*;
(
    input  logic [ALU_OP_W-1:0]  alu_op,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALU_CTR_W-1:0] alu_ctr
);

    alu_ctr_e ctr;

    // Two-level decode: class bit selects which field is examined
    always_comb begin
        ctr = ALU_NOP;
        if (alu_op[3]) begin
            case (funct)
                F_ADD:   ctr = ALU_ADD;
                F_SUB:   ctr = ALU_SUB;
                F_AND:   ctr = ALU_AND;
                F_OR:    ctr = ALU_OR;
                F_XOR:   ctr = ALU_XOR;
                F_NOR:   ctr = ALU_NOR;
                F_SLT:   ctr = ALU_SLT;
                F_SLL:   ctr = ALU_SLL;
                F_SRL:   ctr = ALU_SRL;
                F_MULTU: ctr = ALU_MULTU;
                F_JR:    ctr = ALU_PASS;
                F_JALR:  ctr = ALU_PASS;
                default: ctr = ALU_NOP;
            endcase
        end else begin
            case (alu_op)
                OP_ADD:  ctr = ALU_ADD;
                OP_SLT:  ctr = ALU_SLT;
                OP_SUB:  ctr = ALU_SUB;
                OP_AND:  ctr = ALU_AND;
                OP_OR:   ctr = ALU_OR;
                OP_LUI:  ctr = ALU_LUI;
                default: ctr = ALU_NOP;
            endcase
        end
    end

    assign alu_ctr = ctr;

endmodule

// File: rtl/b_aluctrl.sv
// ALU control unit: wraps the combinational decoder with an optional output
// register. With REGISTERED_OUT=0 the clock and reset are not used at all.
module b_aluctrl
    import b_aluctrl_pkg::*;
#(
    parameter bit REGISTERED_OUT = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ALU_OP_W-1:0]  i_b_aluctrl_alu_op,
    input  logic [FUNCT_W-1:0]   i_b_aluctrl_funct,
    output logic [ALU_CTR_W-1:0] o_b_aluctrl_alu_ctr
);

    logic [ALU_CTR_W-1:0] dec_ctr;

    b_aluctrl_dec u_dec (
        .alu_op  (i_b_aluctrl_alu_op),
        .funct   (i_b_aluctrl_funct),
        .alu_ctr (dec_ctr)
    );

    generate
        if (REGISTERED_OUT) begin : g_reg
            logic [ALU_CTR_W-1:0] ctr_q;

            // Output register; reset parks the ALU on NOP immediately
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    ctr_q <= ALU_NOP;
                end else begin
                    ctr_q <= dec_ctr;
                end
            end

            assign o_b_aluctrl_alu_ctr = ctr_q;
        end else begin : g_comb
            // Clock and reset intentionally have no effect in this variant
            logic unused_clk_rst;
            assign unused_clk_rst      = i_clk ^ i_rst;
            assign o_b_aluctrl_alu_ctr = dec_ctr;
        end
    endgenerate

endmodule

// File: tb/tb_b_aluctrl.sv
// Bench for b_aluctrl: a registered instance on a running clock and a
// combinational instance with an idle clock, both fed the same inputs.
module tb_b_aluctrl;

    logic       clk = 1'b0;
    logic       clk_idle = 1'b0;
    logic       rst = 1'b0;
    logic       rst_idle = 1'b0;
    logic [3:0] alu_op = 4'b0000;
    logic [5:0] funct = 6'b000000;
    logic [3:0] reg_out;
    logic [3:0] comb_out;

    int errors = 0;
    int checks = 0;

    // Reference tables written straight from the decode rules
    logic [3:0] rtab [bit [5:0]];
    logic [3:0] itab [bit [2:0]];
    bit   [5:0] known_funct [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                     6'b100110, 6'b100111, 6'b101010, 6'b000000,
                                     6'b000010, 6'b011001, 6'b001000, 6'b001001};

    b_aluctrl #(.REGISTERED_OUT(1'b1)) u_reg (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_b_aluctrl_alu_op  (alu_op),
        .i_b_aluctrl_funct   (funct),
        .o_b_aluctrl_alu_ctr (reg_out)
    );

    b_aluctrl #(.REGISTERED_OUT(1'b0)) u_comb (
        .i_clk               (clk_idle),
        .i_rst               (rst_idle),
        .i_b_aluctrl_alu_op  (alu_op),
        .i_b_aluctrl_funct   (funct),
        .o_b_aluctrl_alu_ctr (comb_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] model(input bit [3:0] op, input bit [5:0] f);
        if (op >= 4'd8)
            return rtab.exists(f) ? rtab[f] : 4'b1111;
        return itab.exists(op[2:0]) ? itab[op[2:0]] : 4'b1111;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [5:0] f);
        @(negedge clk);
        alu_op = op;
        funct  = f;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        alu_op = 4'b1000;
        funct  = 6'b100000;
        #1;
        checks++;
        if (reg_out !== 4'b1111) begin
            errors++;
            $display("FAIL reset_hold: got %b want 1111", reg_out);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (reg_out !== 4'b1111) begin
            errors++;
            $display("FAIL reset_hold_clk: got %b want 1111", reg_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (reg_out !== 4'b0010) begin
            errors++;
            $display("FAIL reset_release: got %b want 0010", reg_out);
        end
    endtask

    task automatic test_rtype_sweep;
        logic [5:0] fl [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b011001};
        logic [3:0] el [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                                4'b1100, 4'b0111, 4'b0100, 4'b0101, 4'b1000};
        for (int i = 0; i < 10; i++) begin
            drive({1'b1, 3'($urandom_range(0, 7))}, fl[i]);
            @(posedge clk);
            #1;
            checks++;
            if (reg_out !== el[i]) begin
                errors++;
                $display("FAIL rtype_%b: got %b want %b", fl[i], reg_out, el[i]);
            end
            checks++;
            if (comb_out !== el[i]) begin
                errors++;
                $display("FAIL rtype_comb_%b: got %b want %b", fl[i], comb_out, el[i]);
            end
        end
    endtask

    task automatic test_pass_nop;
        logic [5:0] fl [3] = '{6'b001000, 6'b001001, 6'b111111};
        logic [3:0] el [3] = '{4'b1010, 4'b1010, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            drive(4'b1000, fl[i]);
            @(posedge clk);
            #1;
            checks++;
            if (reg_out !== el[i]) begin
                errors++;
                $display("FAIL pass_nop_%b: got %b want %b", fl[i], reg_out, el[i]);
            end
        end
    endtask

    task automatic test_itype_xfunct;
        logic [3:0] ol [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0111, 4'b0011};
        logic [3:0] el [7] = '{4'b0010, 4'b0111, 4'b0110, 4'b0000, 4'b0001, 4'b1001, 4'b1111};
        for (int i = 0; i < 7; i++) begin
            drive(ol[i], 6'bxxxxxx);
            @(posedge clk);
            #1;
            checks++;
            if (reg_out !== el[i]) begin
                errors++;
                $display("FAIL itype_%b: got %b want %b", ol[i], reg_out, el[i]);
            end
        end
        drive(4'b0110, 6'bzzzzzz);
        @(posedge clk);
        #1;
        checks++;
        if (reg_out !== 4'b1111) begin
            errors++;
            $display("FAIL itype_0110: got %b want 1111", reg_out);
        end
        drive(4'b1xxx, 6'b100010);
        @(posedge clk);
        #1;
        checks++;
        if (reg_out !== 4'b0110) begin
            errors++;
            $display("FAIL rtype_xop: got %b want 0110", reg_out);
        end
    endtask

    task automatic test_async_reset;
        drive(4'b0010, 6'b000000);
        @(posedge clk);
        #1;
        checks++;
        if (reg_out !== 4'b0110) begin
            errors++;
            $display("FAIL async_pre: got %b want 0110", reg_out);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (reg_out !== 4'b1111) begin
            errors++;
            $display("FAIL async_assert: got %b want 1111", reg_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (reg_out !== 4'b0110) begin
            errors++;
            $display("FAIL async_release: got %b want 0110", reg_out);
        end
    endtask

    task automatic test_comb;
        drive(4'b0101, 6'b100000);
        #1;
        checks++;
        if (comb_out !== 4'b0001) begin
            errors++;
            $display("FAIL comb_0101: got %b want 0001", comb_out);
        end
    endtask

    task automatic test_back_to_back;
        bit [3:0] op;
        bit [5:0] f;
        logic [3:0] exp;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                f = known_funct[$urandom_range(0, 11)];
            else
                f = 6'($urandom_range(0, 63));
            exp = model(op, f);
            drive(op, f);
            #1;
            checks++;
            if (comb_out !== exp) begin
                errors++;
                $display("FAIL b2b_comb op=%b f=%b: got %b want %b", op, f, comb_out, exp);
            end
            @(posedge clk);
            #1;
            checks++;
            if (reg_out !== exp) begin
                errors++;
                $display("FAIL b2b_reg op=%b f=%b: got %b want %b", op, f, reg_out, exp);
            end
        end
    endtask

    initial begin
        rtab[6'b100000] = 4'b0010;
        rtab[6'b100010] = 4'b0110;
        rtab[6'b100100] = 4'b0000;
        rtab[6'b100101] = 4'b0001;
        rtab[6'b100110] = 4'b0011;
        rtab[6'b100111] = 4'b1100;
        rtab[6'b101010] = 4'b0111;
        rtab[6'b000000] = 4'b0100;
        rtab[6'b000010] = 4'b0101;
        rtab[6'b011001] = 4'b1000;
        rtab[6'b001000] = 4'b1010;
        rtab[6'b001001] = 4'b1010;
        itab[3'b000] = 4'b0010;
        itab[3'b001] = 4'b0111;
        itab[3'b010] = 4'b0110;
        itab[3'b100] = 4'b0000;
        itab[3'b101] = 4'b0001;
        itab[3'b111] = 4'b1001;

        test_reset();
        test_rtype_sweep();
        test_pass_nop();
        test_itype_xfunct();
        test_async_reset();
        test_comb();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
